jk_exciter: RTL and testbench



---
 rtl/jk_exciter_if.sv | 30 +++
 rtl/jk_exciter.sv | 126 ++++++++++++
 tb/tb_jk_exciter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/jk_exciter_if.sv
// jk_exciter_if
//   Bundles the target handshake, the JK excitation bus and the status
//   pulses of jk_exciter.
//   slave  : the exciter side (takes the target and q, drives j/k and status)
//   master : the environment side (offers targets, owns the flop bank)
//   Signals: tgt_valid, tgt_ready, tgt_data[WIDTH], j[WIDTH], k[WIDTH],
//            q[WIDTH], busy, done, err
interface jk_exciter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  tgt_valid, tgt_data, q,
        output tgt_ready, j, k, busy, done, err
    );

    modport master (
        output tgt_valid, tgt_data, q,
        input  tgt_ready, j, k, busy, done, err
    );
endinterface

// File: rtl/jk_exciter.sv
// jk_exciter
//   Drives one cycle of per-bit J/K excitation to move an external JK flop
//   bank to a target word, reads q back and reports done, or retries up to
//   MAX_RETRY attempts before reporting err.
//   Ports:
//     clk : clock, all state changes on posedge
//     rst : synchronous reset, active-high
//     ex  : jk_exciter_if.slave (target handshake, j/k/q, busy/done/err)
//   Parameters: WIDTH (flops in the bank), MAX_RETRY (1..15 attempts)
//   Build option: JK_EXCITER_TOGGLE_EN selects the toggle encoding (J=K=1 on
//   every changing bit); left undefined, set/reset encoding is used.
module jk_exciter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic          clk,
    input  logic          rst,
    jk_exciter_if.slave   ex
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK
    } state_t;

    localparam logic [3:0] LP_MAX_RETRY = 4'(MAX_RETRY);

    state_t           r_state;
    logic [3:0]       r_retry;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [WIDTH-1:0] w_tgt_src;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    // Excitation is computed for the edge that enters DRIVE: from the
    // incoming word when leaving IDLE, from the held target on a retry.
    assign w_tgt_src = (r_state == ST_IDLE) ? ex.tgt_data : r_tgt;

    always_comb begin
`ifdef JK_EXCITER_TOGGLE_EN
        w_j = ex.q ^ w_tgt_src;
        w_k = ex.q ^ w_tgt_src;
`else
        w_j = ~ex.q & w_tgt_src;
        w_k = ex.q & ~w_tgt_src;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_retry <= '0;
            r_tgt   <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // tgt_ready is high throughout IDLE, so valid alone
                    // completes the transfer here.
                    if (ex.tgt_valid) begin
                        r_tgt   <= ex.tgt_data;
                        r_retry <= '0;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_retry <= r_retry + 4'd1;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (ex.q == r_tgt) begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_retry < LP_MAX_RETRY) begin
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ex.tgt_ready = r_ready;
    assign ex.j         = r_j;
    assign ex.k         = r_k;
    assign ex.busy      = r_busy;
    assign ex.done      = r_done;
    assign ex.err       = r_err;

endmodule

// File: tb/tb_jk_exciter.sv
// tb_jk_exciter
//   Bench for jk_exciter with a JK flop bank model (optional stuck-at-0 bits)
//   and a transaction-level prediction of outcome, latency and final q.
module tb_jk_exciter;

    localparam int unsigned W  = 8;
    localparam int unsigned MR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_exciter_if #(.WIDTH(W)) bus ();

    jk_exciter #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    // Flop bank: ideal JK flops, bits set in 'stuck' are held at 0.
    logic [W-1:0] bank_q;
    logic [W-1:0] stuck;
    logic [W-1:0] load_val;
    logic         load_en;

    always @(posedge clk) begin
        if (load_en)
            bank_q <= load_val & ~stuck;
        else
            bank_q <= ((bus.j & ~bank_q) | (~bus.k & bank_q)) & ~stuck;
    end
    assign bus.q = bank_q;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected excitation for moving bank value qv to target tv.
    function automatic logic [W-1:0] exp_j(input logic [W-1:0] qv, input logic [W-1:0] tv);
`ifdef JK_EXCITER_TOGGLE_EN
        return qv ^ tv;
`else
        return tv & ~qv;
`endif
    endfunction

    function automatic logic [W-1:0] exp_k(input logic [W-1:0] qv, input logic [W-1:0] tv);
`ifdef JK_EXCITER_TOGGLE_EN
        return qv ^ tv;
`else
        return qv & ~tv;
`endif
    endfunction

    task automatic load_bank(input logic [W-1:0] v, input logic [W-1:0] stk);
        @(negedge clk);
        stuck    = stk;
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // One full transaction; the end cycle L is predicted from the outcome.
    task automatic run_txn(input logic [W-1:0] q0, input logic [W-1:0] t, input logic [W-1:0] stk);
        logic [W-1:0] q_after;
        logic [W-1:0] q_cur;
        logic         ok;
        int unsigned  len;
        load_bank(q0 & ~stk, stk);
        q_after = t & ~stk;
        ok      = (q_after == t);
        len     = ok ? 2 : 2 * MR;
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = t;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        for (int unsigned c = 0; c <= len; c++) begin
            if (c < len) begin
                chk("busy_mid", bus.busy, 1'b1);
                chk("pulse_mid", {bus.done, bus.err}, 2'b00);
                q_cur = (c == 0) ? (q0 & ~stk) : q_after;
                if (c % 2 == 0) begin
                    chk("drive_j", bus.j, exp_j(q_cur, t));
                    chk("drive_k", bus.k, exp_k(q_cur, t));
                end else begin
                    chk("hold_jk", {bus.j, bus.k}, '0);
                end
                @(negedge clk);
            end else begin
                chk("end_done", bus.done, ok);
                chk("end_err", bus.err, !ok);
                chk("end_ready", {bus.busy, bus.tgt_ready}, 2'b01);
                chk("end_q", bank_q, q_after);
            end
        end
    endtask

    initial begin
        logic [W-1:0] rq;
        logic [W-1:0] rt;
        logic [W-1:0] rs;

        bus.tgt_valid = 1'b0;
        bus.tgt_data  = '0;
        stuck         = '0;
        load_en       = 1'b1;
        load_val      = '0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_jk", {bus.j, bus.k}, '0);
        chk("rst_status", {bus.busy, bus.done, bus.err, bus.tgt_ready}, 4'b0001);
        rst     = 1'b0;
        load_en = 1'b0;

        // Directed cases
        run_txn(8'h00, 8'hA5, 8'h00);
        run_txn(8'hF0, 8'h3C, 8'h00);
        run_txn(8'h00, 8'h01, 8'h01);
        run_txn(8'h5A, 8'h5A, 8'h00);

        // Back-to-back with valid held: 0x22 offered while busy is ignored.
        load_bank(8'h00, 8'h00);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'h11;
        @(negedge clk);
        chk("b2b_first_j", bus.j, exp_j(8'h00, 8'h11));
        bus.tgt_data = 8'h22;
        @(negedge clk);
        chk("b2b_ignored", bus.busy, 1'b1);
        @(negedge clk);
        chk("b2b_done1", {bus.done, bus.tgt_ready}, 2'b11);
        chk("b2b_q1", bank_q, 8'h11);
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("b2b_second_j", bus.j, exp_j(8'h11, 8'h22));
        chk("b2b_second_k", bus.k, exp_k(8'h11, 8'h22));
        @(negedge clk);
        chk("b2b_gap", bus.done, 1'b0);
        @(negedge clk);
        chk("b2b_done2", bus.done, 1'b1);
        chk("b2b_q2", bank_q, 8'h22);

        // Reset while in DRIVE.
        load_bank(8'h00, 8'h00);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'hFF;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("rd_drive_j", bus.j, exp_j(8'h00, 8'hFF));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rd_jk", {bus.j, bus.k}, '0);
        chk("rd_status", {bus.busy, bus.done, bus.err, bus.tgt_ready}, 4'b0001);
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rd_quiet", {bus.busy, bus.done, bus.err, bus.tgt_ready}, 4'b0001);
        end

        // Randomized transactions, some with stuck bits.
        for (int unsigned n = 0; n < 40; n++) begin
            rq = W'($urandom);
            rt = W'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 7) == 0) rt = rq;
            run_txn(rq, rt, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
